temp_monitor_seq: RTL
=====================

TEMP_MONITOR_SEQ -- requirements
Module: temp_monitor_seq

Interface
REQ-001 Parameter S_NR, default 3: number of temperature sensors, range 1..16.
REQ-002 Parameter TEMP_WIDTH, default 5: unsigned bits per sensor reading.
REQ-003 Parameter T_MIN, default 19: lowest in-range temperature.
REQ-004 Parameter T_MAX, default 26: highest in-range temperature; T_MIN < T_MAX < 2**TEMP_WIDTH.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 start  in  1  request; sampled only while ready=1.
REQ-008 value  in  S_NR*TEMP_WIDTH  packed readings; sensor k at bits [k*TEMP_WIDTH +: TEMP_WIDTH].
REQ-009 enable  in  S_NR  bit k=1 includes sensor k in the average.
REQ-010 ready  out  1  high in IDLE only.
REQ-011 valid  out  1  one-cycle pulse marking new avg/led_output/alert.
REQ-012 avg  out  TEMP_WIDTH  average of enabled sensors.
REQ-013 led_output  out  T_MAX-T_MIN+1  thermometer bar.
REQ-014 alert  out  1  out-of-range or no-sensor indication.

Function
REQ-015 SUM_W = TEMP_WIDTH + clog2(S_NR+1); sum, count and divider operate at SUM_W bits with no overflow.
REQ-016 FSM states IDLE, SUM, DIV, DONE; IDLE->SUM on start&ready, capturing value and enable into internal registers.
REQ-017 SUM: one sensor per cycle, index 0..S_NR-1, adds reading to sum and 1 to count when its enable bit is set; exactly S_NR cycles, then DIV.
REQ-018 DIV: restoring divide sum/count, one quotient bit per cycle, exactly SUM_W cycles, then DONE.
REQ-019 DONE: registers avg, led_output, alert, asserts valid for that single cycle, returns to IDLE next edge.
REQ-020 Fixed latency: valid high S_NR+SUM_W+1 rising edges after the accepting edge (11 at defaults), independent of data.
REQ-021 start while ready=0 is ignored; inputs changing after acceptance do not affect the result.
REQ-022 count=0: divider skipped internally but cycle count preserved; avg=0, led_output=0, alert=1.
REQ-023 avg < T_MIN: led_output all 0, alert=1.
REQ-024 avg > T_MAX: led_output all 1, alert=1.
REQ-025 T_MIN <= avg <= T_MAX: led_output bits 0..(avg-T_MIN) set, rest clear, alert=0.
REQ-026 avg, led_output, alert hold their value between DONE cycles.

Reset
REQ-027 rst_n=0 at a rising edge forces IDLE, ready=1, valid=0, avg=0, led_output=0, alert=0, sum/count/divider cleared, from any state including mid-SUM/DIV; an aborted request produces no valid.

Configuration
REQ-028 Macro TM_ROUND_EN defined: avg = quotient+1 when 2*remainder >= count (count>0), saturated at 2**TEMP_WIDTH-1; range checks use the rounded avg.
REQ-029 TM_ROUND_EN undefined: avg = truncated quotient; latency unchanged in both builds.

Structure
REQ-030 Package tm_pkg holds the FSM state enum and the clog2-based SUM_W helper function.
REQ-031 Sub-module tm_seq_divider: SUM_W-bit restoring divider with start/done, quotient and remainder outputs, instantiated once.

Verification (defaults unless stated)
REQ-032 value={25,24,20} (sensors 2,1,0), enable=3'b111, start -> valid after 11 edges, avg=23, led_output=8'b0001_1111, alert=0.
REQ-033 sensors 0,1=20,21, enable=3'b011 -> no TM_ROUND_EN: avg=20, led=8'b0000_0011; with TM_ROUND_EN: avg=21, led=8'b0000_0111; alert=0 both.
REQ-034 value={31,31,30}, enable=3'b111 -> avg=30 (31 with TM_ROUND_EN), led_output=8'hFF, alert=1.
REQ-035 enable=3'b000, any value -> valid after 11 edges, avg=0, led_output=0, alert=1.
REQ-036 rst_n low for one edge during DIV -> ready=1 next cycle, valid never pulses for aborted request, outputs 0; new start completes normally.
REQ-037 start held high continuously -> accepted only in IDLE, one result per 12 cycles, input changes during busy do not alter that result.

Source files
------------

// File: rtl/tm_pkg.sv
// ============================================================
// Package : tm_pkg
// Brief   : Shared FSM state encoding and accumulator width helper.
// Rev     : 1.0  initial release
// ============================================================
`default_nettype none

package tm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUM  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } tm_state_e;

  // Accumulator width: S_NR full-scale readings summed without overflow.
  function automatic int tm_sum_w(input int temp_width, input int s_nr);
    return temp_width + $clog2(s_nr + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tm_seq_divider.sv
// ============================================================
// Module : tm_seq_divider
// Brief  : Restoring divider, one quotient bit per cycle, SUM_W steps.
// Rev    : 1.0  initial release
// ============================================================
`default_nettype none

module tm_seq_divider #(
  parameter int SUM_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [SUM_W-1:0] i_dividend,
  input  logic [SUM_W-1:0] i_divisor,
  output logic             o_done,
  output logic [SUM_W-1:0] o_quotient,
  output logic [SUM_W-1:0] o_remainder
);

  localparam int LEFT_W = $clog2(SUM_W);

  logic [SUM_W-1:0]  r_a;
  logic [SUM_W-1:0]  r_q;
  logic [SUM_W-1:0]  r_d;
  logic [LEFT_W-1:0] r_left;
  logic              r_busy;
  logic              r_done;

  logic [SUM_W-1:0]  w_a_in;
  logic [SUM_W-1:0]  w_q_in;
  logic [SUM_W-1:0]  w_d_in;
  logic [SUM_W:0]    w_shift;
  logic [SUM_W-1:0]  w_sub;
  logic              w_ge;
  logic [SUM_W-1:0]  w_a_nxt;
  logic [SUM_W-1:0]  w_q_nxt;

  // The loading cycle already performs the first step, so the last
  // quotient bit lands one cycle before the caller's DIV window closes.
  always_comb begin
    w_a_in  = i_start ? '0 : r_a;
    w_q_in  = i_start ? i_dividend : r_q;
    w_d_in  = i_start ? i_divisor : r_d;
    w_shift = {w_a_in, w_q_in[SUM_W-1]};
    w_ge    = (w_shift >= {1'b0, w_d_in});
    w_sub   = w_shift[SUM_W-1:0] - w_d_in;
    w_a_nxt = w_ge ? w_sub : w_shift[SUM_W-1:0];
    w_q_nxt = {w_q_in[SUM_W-2:0], w_ge};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_q    <= '0;
      r_d    <= '0;
      r_left <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_d    <= i_divisor;
        r_a    <= w_a_nxt;
        r_q    <= w_q_nxt;
        r_left <= LEFT_W'(SUM_W - 1);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_a    <= w_a_nxt;
        r_q    <= w_q_nxt;
        r_left <= r_left - 1'b1;
        if (r_left == LEFT_W'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done      = r_done;
  assign o_quotient  = r_q;
  assign o_remainder = r_a;

endmodule

`default_nettype wire

// File: rtl/temp_monitor_seq.sv
// ============================================================
// Module : temp_monitor_seq
// Brief  : Sequential multi-sensor temperature average with LED bar/alert.
// Config : define TM_ROUND_EN for round-half-up average (saturating).
// Rev    : 1.0  initial release
// ============================================================
`default_nettype none

module temp_monitor_seq
  import tm_pkg::*;
#(
  parameter int S_NR       = 3,
  parameter int TEMP_WIDTH = 5,
  parameter int T_MIN      = 19,
  parameter int T_MAX      = 26
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [S_NR*TEMP_WIDTH-1:0] value,
  input  logic [S_NR-1:0]            enable,
  output logic                       ready,
  output logic                       valid,
  output logic [TEMP_WIDTH-1:0]      avg,
  output logic [T_MAX-T_MIN:0]       led_output,
  output logic                       alert
);

  localparam int SUM_W = tm_sum_w(TEMP_WIDTH, S_NR);
  localparam int LED_W = T_MAX - T_MIN + 1;
  localparam int CNT_W = $clog2(((S_NR > SUM_W) ? S_NR : SUM_W) + 1);

  tm_state_e                   r_state;
  logic [CNT_W-1:0]            r_idx;
  logic [S_NR*TEMP_WIDTH-1:0]  r_value;
  logic [S_NR-1:0]             r_enable;
  logic [SUM_W-1:0]            r_sum;
  logic [SUM_W-1:0]            r_cnt;
  logic                        r_ready;
  logic                        r_valid;
  logic [TEMP_WIDTH-1:0]       r_avg;
  logic [LED_W-1:0]            r_led;
  logic                        r_alert;

  logic [SUM_W-1:0]            w_sum_nxt;
  logic [SUM_W-1:0]            w_cnt_nxt;
  logic                        w_sum_last;
  logic                        w_div_last;
  logic                        w_div_start;
  logic                        w_div_done;
  logic [SUM_W-1:0]            w_quot;
  logic [SUM_W-1:0]            w_rem;
  logic                        w_have_q;
  logic [TEMP_WIDTH-1:0]       w_avg;
  logic [LED_W-1:0]            w_led;
  logic                        w_alert;

  // Captured readings are shifted down so sensor k sits in the low slot
  // during its SUM cycle.
  always_comb begin
    w_sum_nxt   = r_sum + (r_enable[0] ? SUM_W'(r_value[TEMP_WIDTH-1:0]) : '0);
    w_cnt_nxt   = r_cnt + SUM_W'(r_enable[0]);
    w_sum_last  = (r_state == ST_SUM) && (r_idx == CNT_W'(S_NR - 1));
    w_div_last  = (r_state == ST_DIV) && (r_idx == CNT_W'(SUM_W - 1));
    w_div_start = w_sum_last && (w_cnt_nxt != '0);
  end

  tm_seq_divider #(
    .SUM_W (SUM_W)
  ) u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (w_div_start),
    .i_dividend  (w_sum_nxt),
    .i_divisor   (w_cnt_nxt),
    .o_done      (w_div_done),
    .o_quotient  (w_quot),
    .o_remainder (w_rem)
  );

`ifdef TM_ROUND_EN
  localparam logic [SUM_W:0] AVG_MAX_EXT = (SUM_W + 1)'((1 << TEMP_WIDTH) - 1);
  logic [SUM_W:0] w_rnd;

  always_comb begin
    w_rnd = {1'b0, w_quot} + {{SUM_W{1'b0}}, ({w_rem, 1'b0} >= {1'b0, r_cnt})};
    w_avg = '0;
    if (w_have_q) begin
      w_avg = (w_rnd > AVG_MAX_EXT) ? '1 : w_rnd[TEMP_WIDTH-1:0];
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{w_quot[SUM_W-1:TEMP_WIDTH], w_rem};

  always_comb begin
    w_avg = w_have_q ? w_quot[TEMP_WIDTH-1:0] : '0;
  end
`endif

  // Thermometer bar: bit i lights once avg reaches T_MIN+i, which also
  // gives all-zero below range and all-one above it.
  always_comb begin
    w_have_q = w_div_done && (r_cnt != '0);
    w_led    = '0;
    for (int i = 0; i < LED_W; i++) begin
      w_led[i] = w_have_q && (int'(w_avg) >= T_MIN + i);
    end
    w_alert = !w_have_q || (int'(w_avg) < T_MIN) || (int'(w_avg) > T_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_value  <= '0;
      r_enable <= '0;
      r_sum    <= '0;
      r_cnt    <= '0;
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
      r_avg    <= '0;
      r_led    <= '0;
      r_alert  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_valid <= 1'b0;
          if (start) begin
            r_value  <= value;
            r_enable <= enable;
            r_sum    <= '0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_ready  <= 1'b0;
            r_state  <= ST_SUM;
          end
        end
        ST_SUM: begin
          r_sum    <= w_sum_nxt;
          r_cnt    <= w_cnt_nxt;
          r_value  <= r_value >> TEMP_WIDTH;
          r_enable <= r_enable >> 1;
          if (w_sum_last) begin
            r_idx   <= '0;
            r_state <= ST_DIV;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DIV: begin
          // The DIV window length is fixed even when the divider was skipped.
          if (w_div_last) begin
            r_idx   <= '0;
            r_avg   <= w_avg;
            r_led   <= w_led;
            r_alert <= w_alert;
            r_valid <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: begin
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_valid <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready      = r_ready;
  assign valid      = r_valid;
  assign avg        = r_avg;
  assign led_output = r_led;
  assign alert      = r_alert;

endmodule

`default_nettype wire
